// File: rtl/swc_output_arbiter.sv
// rtl/swc_output_arbiter.sv - priority/round-robin output arbiter with hold limit
// One grant at a time; each grant is followed by a one-cycle GAP before the next arbitration.
module swc_output_arbiter #(
  parameter int g_num_ports  = 7,
  parameter int g_prio_width = 3,
  parameter int g_max_hold   = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [g_num_ports-1:0]              req_i,
  input  logic [g_num_ports*g_prio_width-1:0] prio_i,
  input  logic [g_num_ports-1:0]              eof_i,
  output logic [g_num_ports-1:0]              gnt_o,
  output logic                                gnt_valid_o,
  output logic [$clog2(g_num_ports)-1:0]      gnt_idx_o,
  output logic                                timeout_o
);

  localparam int IdxW = $clog2(g_num_ports);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t            state_q, state_d;
  logic [IdxW-1:0]   winner_q, winner_d;
  logic [IdxW-1:0]   last_ptr_q, last_ptr_d;
  logic [15:0]       hold_q, hold_d;
  logic              timeout_q, timeout_d;
  logic              armed_q;

  logic [IdxW-1:0]         sel_idx, cand_idx;
  logic                    sel_found;
  logic [g_prio_width-1:0] best_prio, cand_prio;
  int                      cand;

  logic win_req, win_eof, hold_limit;

  // Scan ports in rotation order starting after last_ptr; strict '>' keeps the first tied port.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_prio = '0;
    cand      = 0;
    cand_idx  = '0;
    cand_prio = '0;
    for (int i = 0; i < g_num_ports; i++) begin
      cand      = (int'(last_ptr_q) + 1 + i) % g_num_ports;
      cand_idx  = IdxW'(cand);
      cand_prio = prio_i[cand_idx*g_prio_width +: g_prio_width];
      if (req_i[cand_idx] && (!sel_found || (cand_prio > best_prio))) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
        best_prio = cand_prio;
      end
    end
  end

  assign win_req    = req_i[winner_q];
  assign win_eof    = eof_i[winner_q];
  assign hold_limit = (hold_q == 16'(g_max_hold - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (armed_q && sel_found) state_d = GRANT;
      GRANT:   if (win_eof || !win_req || hold_limit) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A normal release (eof or request drop) takes precedence over the hold limit.
  always_comb begin
    winner_d   = winner_q;
    last_ptr_d = last_ptr_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    if ((state_q == IDLE) && (state_d == GRANT)) begin
      winner_d   = sel_idx;
      last_ptr_d = sel_idx;
      hold_d     = '0;
    end else if ((state_q == GRANT) && (hold_q != 16'hFFFF)) begin
      hold_d = hold_q + 16'd1;
    end
    if ((state_q == GRANT) && hold_limit && win_req && !win_eof) begin
      timeout_d = 1'b1;
    end
  end

  // armed_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      winner_q   <= '0;
      last_ptr_q <= IdxW'(g_num_ports - 1);
      hold_q     <= '0;
      timeout_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      winner_q   <= winner_d;
      last_ptr_q <= last_ptr_d;
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
      armed_q    <= 1'b1;
    end
  end

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    timeout_o   = timeout_q;
    if (state_q == GRANT) begin
      gnt_o[winner_q] = 1'b1;
      gnt_idx_o       = winner_q;
      gnt_valid_o     = 1'b1;
    end
  end

endmodule

// File: tb/tb_swc_output_arbiter.sv
// tb/tb_swc_output_arbiter.sv - directed self-checking bench for swc_output_arbiter
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_swc_output_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  req;
  logic [20:0] prio;
  logic [6:0]  eof;
  logic [6:0]  gnt;
  logic        valid;
  logic [2:0]  idx;
  logic        tout;

  int checks = 0;
  int errors = 0;

  swc_output_arbiter #(
    .g_num_ports  (7),
    .g_prio_width (3),
    .g_max_hold   (16)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .prio_i      (prio),
    .eof_i       (eof),
    .gnt_o       (gnt),
    .gnt_valid_o (valid),
    .gnt_idx_o   (idx),
    .timeout_o   (tout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 7'b0000101;
    prio  = '0;
    eof   = '0;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_idx", 32'(idx), 32'h0);
    chk("rst_timeout", 32'(tout), 32'h0);

    // Tie rotation between ports 0 and 2, eof in the third grant cycle
    rst_n = 1'b1;
    step();
    chk("first_edge_no_grant", 32'(gnt), 32'h0);
    step();
    chk("tie_gnt_a", 32'(gnt), 32'h01);
    chk("tie_idx_a", 32'(idx), 32'd0);
    chk("tie_valid_a", 32'(valid), 32'h1);
    step();
    step();
    eof = 7'b0000001;
    step();
    eof = '0;
    chk("tie_gap_a", 32'(gnt), 32'h0);
    chk("tie_gap_valid_a", 32'(valid), 32'h0);
    chk("tie_gap_timeout_a", 32'(tout), 32'h0);
    step();
    chk("tie_idle_a", 32'(gnt), 32'h0);
    step();
    chk("tie_gnt_b", 32'(gnt), 32'h04);
    chk("tie_idx_b", 32'(idx), 32'd2);
    eof = 7'b0000001;
    step();
    eof = '0;
    chk("foreign_eof_ignored", 32'(gnt), 32'h04);
    step();
    eof = 7'b0000100;
    step();
    eof = '0;
    chk("tie_gap_b", 32'(gnt), 32'h0);
    step();
    step();
    chk("tie_gnt_c", 32'(gnt), 32'h01);
    chk("tie_idx_c", 32'(idx), 32'd0);
    req = '0;
    step();
    chk("drop_gap_gnt", 32'(gnt), 32'h0);
    chk("drop_gap_timeout", 32'(tout), 32'h0);
    step();

    // Priority override, grant stability, request drop with a pending port
    req        = 7'b1000001;
    prio       = '0;
    prio[20:18] = 3'd5;
    prio[2:0]   = 3'd1;
    step();
    chk("prio_gnt", 32'(gnt), 32'h40);
    chk("prio_idx", 32'(idx), 32'd6);
    prio[2:0] = 3'd7;
    req       = 7'b1000011;
    step();
    chk("grant_stable_gnt", 32'(gnt), 32'h40);
    chk("grant_stable_idx", 32'(idx), 32'd6);
    req = 7'b0000011;
    step();
    chk("reqdrop_gap_gnt", 32'(gnt), 32'h0);
    chk("reqdrop_gap_timeout", 32'(tout), 32'h0);
    step();
    chk("reqdrop_idle_gnt", 32'(gnt), 32'h0);
    step();
    chk("pending_gnt", 32'(gnt), 32'h01);
    chk("pending_idx", 32'(idx), 32'd0);
    req  = '0;
    prio = '0;
    step();
    step();

    // Hold limit: port 3 never sends eof
    req = 7'b0001000;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("hold_gnt", 32'(gnt), 32'h08);
      chk("hold_no_timeout", 32'(tout), 32'h0);
    end
    step();
    chk("timeout_gap_gnt", 32'(gnt), 32'h0);
    chk("timeout_pulse", 32'(tout), 32'h1);
    req = '0;
    step();
    chk("timeout_one_cycle", 32'(tout), 32'h0);
    chk("timeout_idle_gnt", 32'(gnt), 32'h0);

    // eof coinciding with the hold limit counts as a normal release
    req = 7'b0001000;
    for (int i = 0; i < 16; i++) begin
      step();
    end
    chk("coinc_last_cycle_gnt", 32'(gnt), 32'h08);
    eof = 7'b0001000;
    step();
    eof = '0;
    req = '0;
    chk("coinc_gap_gnt", 32'(gnt), 32'h0);
    chk("coinc_no_timeout", 32'(tout), 32'h0);
    step();

    // Reset mid-grant, then an all-zero-priority tie goes to port 0
    req = 7'b0010000;
    step();
    chk("pre_rst_gnt", 32'(gnt), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_gnt", 32'(gnt), 32'h0);
    chk("rst_async_valid", 32'(valid), 32'h0);
    chk("rst_async_timeout", 32'(tout), 32'h0);
    req = 7'b1111111;
    step();
    chk("rst_hold_timeout", 32'(tout), 32'h0);
    rst_n = 1'b1;
    step();
    chk("rst_rel_edge1_no_gnt", 32'(gnt), 32'h0);
    step();
    chk("rst_tie_gnt", 32'(gnt), 32'h01);
    chk("rst_tie_idx", 32'(idx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/swc_output_arbiter.md
SWC_OUTPUT_ARBITER -- requirements
Module: swc_output_arbiter

Interface
REQ-001 Parameter g_num_ports, default 7: number of requesting input ports; legal range 2..16.
REQ-002 Parameter g_prio_width, default 3: width of each per-port priority field.
REQ-003 Parameter g_max_hold, default 1024: maximum grant duration in cycles; legal range 1..65535.
REQ-004 clk_i  input  1  single system clock; all logic is rising-edge.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 req_i  input  g_num_ports  per-port request for the shared output; level-sensitive.
REQ-007 prio_i  input  g_num_ports*g_prio_width  per-port priority; port k occupies bits [k*g_prio_width +: g_prio_width]; larger value means higher priority.
REQ-008 eof_i  input  g_num_ports  per-port end-of-frame strobe; only the bit of the granted port is observed.
REQ-009 gnt_o  output  g_num_ports  registered one-hot grant; all zeros when no grant is active.
REQ-010 gnt_valid_o  output  1  high exactly when gnt_o is non-zero.
REQ-011 gnt_idx_o  output  clog2(g_num_ports)  binary index of the granted port; 0 when no grant is active.
REQ-012 timeout_o  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-013 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-014 IDLE: when any req_i bit is high at a rising edge, SHALL select a winner, move to GRANT and assert gnt_o for the winner from the next cycle (one-cycle latency); otherwise SHALL stay in IDLE.
REQ-015 Winner selection SHALL use the highest prio_i value among requesting ports.
REQ-016 Ties SHALL be broken round-robin, searching from index (last_ptr+1) mod g_num_ports upward with wrap-around.
REQ-017 last_ptr SHALL load the winner index on every IDLE->GRANT transition.
REQ-018 GRANT: gnt_o, gnt_idx_o and the winner SHALL stay stable; changes on req_i or prio_i from other ports SHALL be ignored.
REQ-019 The hold counter (16 bits) SHALL clear on entry to GRANT and increment by one each GRANT cycle; it SHALL saturate and never wrap.
REQ-020 GRANT->GAP SHALL occur at the edge where eof_i[winner]=1, where req_i[winner]=0, or where the counter equals g_max_hold-1, whichever comes first.
REQ-021 timeout_o SHALL pulse for one cycle, in the first GAP cycle, only when the exit cause is the hold limit.
REQ-022 If eof_i[winner] or a req_i[winner] drop coincides with the hold limit, the exit SHALL count as a normal release and timeout_o SHALL stay 0.
REQ-023 GAP SHALL last exactly one cycle with gnt_o=0 and then return to IDLE, so grants are separated by at least one idle cycle.
REQ-024 A grant request from the same port SHALL be eligible again after GAP; round-robin then favours other equal-priority ports.
REQ-025 eof_i bits of non-granted ports and eof_i in IDLE or GAP SHALL be ignored.
REQ-026 With g_max_hold=1, each grant SHALL last exactly one cycle.

Reset
REQ-027 While rst_n_i=0, gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, timeout_o=0, state=IDLE, hold counter=0 and last_ptr=g_num_ports-1, so port 0 wins the first tie.
REQ-028 Asserting reset mid-grant SHALL drop gnt_o asynchronously in the same cycle, with no timeout_o pulse.
REQ-029 After rst_n_i deasserts, the first grant SHALL appear no earlier than the second rising edge.

Verification
REQ-030 Tie rotation: req_i=7'b0000101 held, all prio=0, eof pulses 3 cycles into each grant -> grants to port 0, then port 2, then port 0, each separated by one GAP cycle.
REQ-031 Priority override: req_i=7'b1000001, prio6=5, prio0=1 -> gnt_o=7'b1000000 and gnt_idx_o=6 one cycle after the request.
REQ-032 Timeout: g_max_hold=16, port 3 requests and never sends eof -> gnt_o[3] high for exactly 16 cycles, then timeout_o pulses once in the GAP cycle.
REQ-033 Coincidence: g_max_hold=16, eof_i[3] on the 16th grant cycle -> release with timeout_o=0.
REQ-034 Request drop: the granted port deasserts req_i mid-frame -> gnt_o=0 on the next cycle, timeout_o=0, and a pending port is granted after the GAP cycle.
REQ-035 Reset mid-grant: rst_n_i pulled low while port 4 is granted -> gnt_o=0 immediately; after release and an all-zero-priority tie, port 0 wins first.
